// File: rtl/sdram_wb_bridge_pkg.sv
// Shared definitions for the SDRAM Wishbone-style bridge:
// FSM encodings, the controller address width and the captured-request record.
package sdram_wb_bridge_pkg;

   localparam int CTL_AW = 22;
   localparam int BUS_AW = 21;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DLY  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Reads always fetch the full word, so both byte masks stay open.
   localparam logic [1:0] DQM_RD = 2'b00;

   typedef struct packed {
      logic              we;
      logic [1:0]        sel;
      logic [BUS_AW-1:0] adr;
      logic [15:0]       wdata;
   } cap_t;

endpackage

// File: rtl/sdram_wb_bridge_rst_stretch.sv
// Holds a downstream reset low until rst_n has been high for DELAY consecutive cycles.
module sdram_wb_bridge_rst_stretch #(
   parameter int DELAY = 4
) (
   input  logic clk_p,
   input  logic rst_n,
   output logic rst_out_n
);

   localparam int CW = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
   localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_p) begin
      if (!rst_n) begin
         cnt       <= '0;
         rst_out_n <= 1'b0;
      end else if (!rst_out_n) begin
         if (cnt == LAST) rst_out_n <= 1'b1;
         else             cnt       <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Bus-to-controller bridge: accepts one kernel SDRAM access at a time, issues it to sdram_top,
// and returns a delayed acknowledge held until the kernel drops its strobe.
module sdram_wb_bridge
   import sdram_wb_bridge_pkg::*;
#(
   parameter int RST_DELAY = 4,
   parameter int ACK_DLY   = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk_p,
   input  logic              rst_n,
   input  logic              sdram_stb,
   input  logic              sdram_we,
   input  logic [1:0]        sdram_sel,
   input  logic [BUS_AW-1:0] sdram_adr,
   input  logic [15:0]       sdram_out,
   output logic [15:0]       sdram_dat,
   output logic              sdram_ack,
   output logic              sdram_ready,
   output logic              ctl_rst_n,
   output logic              ctl_wr_req,
   output logic              ctl_rd_req,
   input  logic              ctl_wr_ack,
   input  logic              ctl_rd_ack,
   output logic [1:0]        ctl_be,
   output logic [CTL_AW-1:0] ctl_addr,
   output logic [15:0]       ctl_wdata,
   input  logic [15:0]       ctl_rdata,
   input  logic              ctl_init,
   output logic              dqm_h,
   output logic              dqm_l,
   output logic              tmo
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [2:0] DLY_LAST = 3'(ACK_DLY - 1);

   logic [1:0] state;
   cap_t       cap;
   logic [7:0] wcnt;
   logic [2:0] dcnt;
   logic       ack_r;
   logic       hit;

   sdram_wb_bridge_rst_stretch #(.DELAY(RST_DELAY)) u_rst_stretch (
      .clk_p     (clk_p),
      .rst_n     (rst_n),
      .rst_out_n (ctl_rst_n)
   );

   assign sdram_ready = ctl_init;
   assign sdram_ack   = ack_r & sdram_stb;
   assign ctl_be      = cap.sel;
   assign ctl_addr    = {1'b0, cap.adr};
   assign ctl_wdata   = cap.wdata;
   // Only the ack matching the issued direction completes the request.
   assign hit         = cap.we ? ctl_wr_ack : ctl_rd_ack;

   always_ff @(posedge clk_p) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cap        <= '0;
         wcnt       <= '0;
         dcnt       <= '0;
         ack_r      <= 1'b0;
         ctl_wr_req <= 1'b0;
         ctl_rd_req <= 1'b0;
         dqm_h      <= 1'b0;
         dqm_l      <= 1'b0;
         sdram_dat  <= '0;
         tmo        <= 1'b0;
      end else begin
         tmo <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sdram_stb && ctl_init && ctl_rst_n) begin
                  cap <= '{we: sdram_we, sel: sdram_sel, adr: sdram_adr, wdata: sdram_out};
                  {dqm_h, dqm_l} <= sdram_we ? ~sdram_sel : DQM_RD;
                  ctl_wr_req <= sdram_we;
                  ctl_rd_req <= !sdram_we;
                  wcnt       <= '0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (hit) begin
                  ctl_wr_req <= 1'b0;
                  ctl_rd_req <= 1'b0;
                  if (!cap.we) sdram_dat <= ctl_rdata;
                  dcnt <= 3'd1;
                  if (ACK_DLY <= 1) begin
                     ack_r <= 1'b1;
                     state <= ST_HOLD;
                  end else begin
                     state <= ST_DLY;
                  end
               end else if (wcnt == TMO_LAST) begin
                  ctl_wr_req <= 1'b0;
                  ctl_rd_req <= 1'b0;
                  tmo        <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            ST_DLY: begin
               if (dcnt == DLY_LAST) begin
                  ack_r <= 1'b1;
                  state <= ST_HOLD;
               end else begin
                  dcnt <= dcnt + 3'd1;
               end
            end
            ST_HOLD: begin
               if (!sdram_stb) begin
                  ack_r <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge with immediate-assertion checks.
module tb_sdram_wb_bridge;

   logic        clk_p = 1'b0;
   logic        rst_n;
   logic        sdram_stb, sdram_we;
   logic [1:0]  sdram_sel;
   logic [20:0] sdram_adr;
   logic [15:0] sdram_out, sdram_dat;
   logic        sdram_ack, sdram_ready, ctl_rst_n;
   logic        ctl_wr_req, ctl_rd_req, ctl_wr_ack, ctl_rd_ack;
   logic [1:0]  ctl_be;
   logic [21:0] ctl_addr;
   logic [15:0] ctl_wdata, ctl_rdata;
   logic        ctl_init, dqm_h, dqm_l, tmo;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_p = ~clk_p;

   sdram_wb_bridge dut (
      .clk_p(clk_p), .rst_n(rst_n),
      .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
      .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
      .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .ctl_rst_n(ctl_rst_n),
      .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
      .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack),
      .ctl_be(ctl_be), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
      .ctl_rdata(ctl_rdata), .ctl_init(ctl_init),
      .dqm_h(dqm_h), .dqm_l(dqm_l), .tmo(tmo)
   );

   task automatic tick;
      @(posedge clk_p);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      rst_n = 0; sdram_stb = 0; sdram_we = 0; sdram_sel = 0; sdram_adr = 0; sdram_out = 0;
      ctl_wr_ack = 0; ctl_rd_ack = 0; ctl_rdata = 0; ctl_init = 0;
      tick; tick;
      chk("rst_ack", sdram_ack, 0);
      chk("rst_wr_req", ctl_wr_req, 0);
      chk("rst_rd_req", ctl_rd_req, 0);
      chk("rst_dqm", {dqm_h, dqm_l}, 0);
      chk("rst_dat", sdram_dat, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_ctl_rst_n", ctl_rst_n, 0);

      // reset stretch: high on the 4th cycle with rst_n=1
      rst_n = 1;
      tick; tick; tick;
      chk("stretch_3", ctl_rst_n, 0);
      tick;
      chk("stretch_4", ctl_rst_n, 1);
      rst_n = 0;
      tick;
      chk("stretch_reassert", ctl_rst_n, 0);
      rst_n = 1;
      tick; tick; tick; tick;
      chk("stretch_again", ctl_rst_n, 1);
      ctl_init = 1;
      #1;
      chk("ready", sdram_ready, 1);

      // write, acked in the 5th request cycle; stray rd_ack ignored; bus changes ignored
      sdram_stb = 1; sdram_we = 1; sdram_sel = 2'b10; sdram_adr = 21'h012345; sdram_out = 16'hBEEF;
      tick;
      chk("wr_addr", ctl_addr, 22'h012345);
      chk("wr_be", ctl_be, 2'b10);
      chk("wr_wdata", ctl_wdata, 16'hBEEF);
      chk("wr_dqm", {dqm_h, dqm_l}, 2'b01);
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("wr_req_c%0d", i), ctl_wr_req, 1);
         chk($sformatf("wr_no_rd_c%0d", i), ctl_rd_req, 0);
         if (i == 3) begin
            chk("wr_addr_hold", ctl_addr, 22'h012345);
            chk("wr_data_hold", ctl_wdata, 16'hBEEF);
            chk("wr_dqm_hold", {dqm_h, dqm_l}, 2'b01);
         end
         ctl_rd_ack = (i == 2);
         ctl_wr_ack = (i == 5);
         if (i == 2) begin sdram_adr = 21'h0; sdram_out = 16'h0; sdram_sel = 2'b01; end
         tick;
      end
      ctl_wr_ack = 0; ctl_rd_ack = 0;
      chk("wr_req_drop", ctl_wr_req, 0);
      chk("wr_ack_dly1", sdram_ack, 0);
      tick;
      chk("wr_ack_rise", sdram_ack, 1);
      tick;
      chk("wr_ack_held", sdram_ack, 1);
      sdram_stb = 0;
      #1;
      chk("wr_ack_comb_drop", sdram_ack, 0);
      tick;

      // read: rdata latched on the ack cycle, dqm open
      sdram_stb = 1; sdram_we = 0; sdram_sel = 2'b01; sdram_adr = 21'h1FFFFF;
      tick;
      chk("rd_req", ctl_rd_req, 1);
      chk("rd_addr", ctl_addr, 22'h1FFFFF);
      chk("rd_dqm", {dqm_h, dqm_l}, 2'b00);
      ctl_rd_ack = 1; ctl_rdata = 16'h1234;
      tick;
      ctl_rd_ack = 0; ctl_rdata = 16'hFFFF;
      chk("rd_req_drop", ctl_rd_req, 0);
      chk("rd_ack_early", sdram_ack, 0);
      tick;
      chk("rd_ack_rise", sdram_ack, 1);
      chk("rd_dat", sdram_dat, 16'h1234);
      sdram_stb = 0;
      tick;
      chk("rd_dat_hold", sdram_dat, 16'h1234);

      // strobe dropped one cycle after acceptance
      sdram_stb = 1; sdram_we = 1; sdram_sel = 2'b11; sdram_adr = 21'h5; sdram_out = 16'hAAAA;
      tick;
      sdram_stb = 0;
      chk("drop_req", ctl_wr_req, 1);
      tick;
      chk("drop_req_still", ctl_wr_req, 1);
      chk("drop_dqm", {dqm_h, dqm_l}, 2'b00);
      ctl_wr_ack = 1;
      tick;
      ctl_wr_ack = 0;
      chk("drop_req_done", ctl_wr_req, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drop_no_ack_%0d", i), sdram_ack, 0);
         tick;
      end

      // next strobe accepted normally; then left unacked to time out
      sdram_stb = 1; sdram_adr = 21'h00ABC;
      tick;
      chk("next_req", ctl_wr_req, 1);
      chk("next_addr", ctl_addr, 22'h000ABC);
      n = 0;
      while (ctl_wr_req && n < 300) begin
         n++;
         chk("tmo_early", tmo, 0);
         tick;
      end
      chk("tmo_cycles", n, 255);
      chk("tmo_pulse", tmo, 1);
      chk("tmo_no_ack", sdram_ack, 0);
      sdram_stb = 0;
      tick;
      chk("tmo_one_cycle", tmo, 0);

      // controller not ready: no acceptance until ctl_init rises
      ctl_init = 0; sdram_stb = 1; sdram_we = 0; sdram_adr = 21'h777;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("noinit_%0d", i), ctl_rd_req, 0);
      end
      ctl_init = 1;
      tick;
      chk("init_req", ctl_rd_req, 1);
      ctl_rd_ack = 1; ctl_rdata = 16'h5A5A;
      tick;
      ctl_rd_ack = 0;
      chk("init_dat", sdram_dat, 16'h5A5A);

      // reset mid-transaction
      rst_n = 0;
      tick;
      chk("midrst_dat", sdram_dat, 0);
      chk("midrst_ctl_rst_n", ctl_rst_n, 0);
      chk("midrst_ack", sdram_ack, 0);
      rst_n = 1; sdram_stb = 0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
